// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU operation codes and response-stage state encoding
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6,
    ALU_NOP  = 3'd7
  } alu_ctrl_t;
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } rsp_state_t;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: combinational ALU producing a result and an operand-equality flag
module alu_comb
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_in1,
  input  logic [DATA_WIDTH-1:0] i_in2,
  input  alu_ctrl_t             i_ctrl,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_eq
);
  // operation select; the reserved code yields zero
  always_comb begin
    o_result = '0;
    case (i_ctrl)
      ALU_ADD:  o_result = i_in1 + i_in2;
      ALU_SUB:  o_result = i_in1 - i_in2;
      ALU_AND:  o_result = i_in1 & i_in2;
      ALU_OR:   o_result = i_in1 | i_in2;
      ALU_XOR:  o_result = i_in1 ^ i_in2;
      ALU_SLT:  o_result = DATA_WIDTH'($signed(i_in1) < $signed(i_in2));
      ALU_SLTU: o_result = DATA_WIDTH'(i_in1 < i_in2);
      default:  o_result = '0;
    endcase
  end
  assign o_eq = i_in1 == i_in2;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters share one ALU behind a one-entry result register (ALU_ARB_FIXED_PRIO_EN selects fixed priority for requester 0)
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_in1,
  input  logic [DATA_WIDTH-1:0] req0_in2,
  input  alu_ctrl_t             req0_ctrl,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_in1,
  input  logic [DATA_WIDTH-1:0] req1_in2,
  input  alu_ctrl_t             req1_ctrl,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_eq
);
  rsp_state_t            r_state;
  rsp_state_t            w_state_nxt;
  logic                  r_last_id;
  logic                  r_id;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_eq;
  logic                  w_gnt;
  logic                  w_can_accept;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_result;
  logic                  w_eq;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_gnt = ~req0_valid & req1_valid;
`else
  assign w_gnt = (req0_valid & req1_valid) ? ~r_last_id : req1_valid;
`endif
  assign w_can_accept = ~rst & (r_state == EMPTY | rsp_ready);
  assign req0_ready   = w_can_accept & ~w_gnt;
  assign req1_ready   = w_can_accept & w_gnt;
  assign w_accept     = w_gnt ? req1_ready & req1_valid : req0_ready & req0_valid;
  alu_comb #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_in1   (w_gnt ? req1_in1 : req0_in1),
    .i_in2   (w_gnt ? req1_in2 : req0_in2),
    .i_ctrl  (w_gnt ? req1_ctrl : req0_ctrl),
    .o_result(w_result),
    .o_eq    (w_eq)
  );
  // response stage: fill on acceptance, drain when consumed with nothing new
  always_comb begin
    w_state_nxt = w_accept ? FULL : (rsp_ready ? EMPTY : r_state);
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else r_state <= w_state_nxt;
  end
  // result capture and round-robin history, both updated only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id      <= 1'b0;
      r_result  <= '0;
      r_eq      <= 1'b0;
      r_last_id <= 1'b1;
    end else if (w_accept) begin
      r_id      <= w_gnt;
      r_result  <= w_result;
      r_eq      <= w_eq;
      r_last_id <= w_gnt;
    end
  end
  assign rsp_valid  = r_state == FULL;
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_eq     = r_eq;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;
  import alu_pkg::*;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b0;
  logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_eq;
  logic [31:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0, rsp_result;
  alu_ctrl_t   req0_ctrl = ALU_ADD, req1_ctrl = ALU_ADD;
  int          n_chk = 0, n_fail = 0;
  bit          m_full = 0, m_last = 1, m_id = 0, m_eq = 0;
  logic [31:0] m_res = '0;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  alu_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in1(req0_in1), .req0_in2(req0_in2), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in1(req1_in1), .req1_in2(req1_in2), .req1_ctrl(req1_ctrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_eq(rsp_eq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input int op);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    bit can, win, acc;
    #1;
    can = !rst && (!m_full || rsp_ready);
    if (req0_valid && req1_valid) win = FIXED ? 1'b0 : !m_last;
    else win = req1_valid;
    acc = can && (req0_valid || req1_valid);
    if (rst || req0_valid) check("req0_ready", req0_ready, acc && win == 0);
    if (rst || req1_valid) check("req1_ready", req1_ready, acc && win == 1);
    check("rsp_valid", rsp_valid, m_full);
    if (m_full) begin
      check("rsp_id", rsp_id, m_id);
      check("rsp_result", rsp_result, m_res);
      check("rsp_eq", rsp_eq, m_eq);
    end
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_last = 1; m_id = 0; m_res = '0; m_eq = 0;
    end else if (acc) begin
      m_full = 1; m_last = win; m_id = win;
      m_res = win ? alu_ref(req1_in1, req1_in2, int'(req1_ctrl)) : alu_ref(req0_in1, req0_in2, int'(req0_ctrl));
      m_eq = win ? (req1_in1 == req1_in2) : (req0_in1 == req0_in2);
    end else if (rsp_ready) m_full = 0;
    #1;
  endtask

  task automatic set0(input logic v, input int op, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_ctrl = alu_ctrl_t'(op[2:0]); req0_in1 = a; req0_in2 = b;
  endtask

  task automatic set1(input logic v, input int op, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_ctrl = alu_ctrl_t'(op[2:0]); req1_in1 = a; req1_in2 = b;
  endtask

  initial begin
    @(posedge clk); #1;
    step(); step();
    check("reset rsp_valid", rsp_valid, 0);
    check("reset rsp_id", rsp_id, 0);
    check("reset rsp_result", rsp_result, 0);
    check("reset rsp_eq", rsp_eq, 0);
    rst = 0; rsp_ready = 1;
    set0(1, 0, 5, 7); step();
    check("add valid", rsp_valid, 1);
    check("add id", rsp_id, 0);
    check("add result", rsp_result, 12);
    check("add eq", rsp_eq, 0);
    set0(1, 0, 1, 2); set1(1, 1, 10, 4);
    for (int i = 0; i < 6; i++) begin
      step();
      check("alternate id", rsp_id, FIXED ? 0 : ((i % 2 == 0) ? 1 : 0));
    end
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall ready0", req0_ready, 0);
      check("stall ready1", req1_ready, 0);
      check("stall result", rsp_result, 3);
      check("stall id", rsp_id, 0);
    end
    rsp_ready = 1; step();
    check("refill valid", rsp_valid, 1);
    check("refill id", rsp_id, FIXED ? 0 : 1);
    check("refill result", rsp_result, FIXED ? 3 : 6);
    set0(0, 0, 0, 0); set1(0, 0, 0, 0); step();
    check("drain valid", rsp_valid, 0);
    set0(1, 1, 0, 1); step();
    check("sub wrap", rsp_result, 32'hFFFF_FFFF);
    set0(0, 0, 0, 0); set1(1, 5, 32'hFFFF_FFFF, 1); step();
    check("slt", rsp_result, 1);
    check("slt id", rsp_id, 1);
    set1(1, 6, 32'hFFFF_FFFF, 1); step();
    check("sltu", rsp_result, 0);
    set1(0, 0, 0, 0); set0(1, 7, 9, 9); step();
    check("nop result", rsp_result, 0);
    check("nop eq", rsp_eq, 1);
    rsp_ready = 0; set0(1, 0, 3, 3); step();
    rst = 1; set1(1, 0, 4, 4); step();
    check("rst mid valid", rsp_valid, 0);
    rst = 0; rsp_ready = 1; step();
    check("post rst grant", rsp_id, 0);
    check("post rst result", rsp_result, 6);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] a0, a1;
      rst = ($urandom_range(0, 49) == 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      a0 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      a1 = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      set0(1'($urandom_range(0, 1)), $urandom_range(0, 7), a0,
           ($urandom_range(0, 3) == 0) ? a0 : (a0[3] ? $urandom : 32'($urandom_range(0, 7))));
      set1(1'($urandom_range(0, 1)), $urandom_range(0, 7), a1,
           ($urandom_range(0, 3) == 0) ? a1 : (a1[3] ? $urandom : 32'($urandom_range(0, 7))));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, operand/result width in bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_in1, req0_in2  input  DATA_WIDTH each  requester 0 operands.
REQ-007 req0_ctrl  input  3  requester 0 ALU operation code (alu_ctrl_t).
REQ-008 req1_valid, req1_ready, req1_in1, req1_in2, req1_ctrl  as REQ-004..007, requester 1.
REQ-009 rsp_valid  output  1  result register holds a valid result.
REQ-010 rsp_ready  input  1  consumer takes result this cycle when high with rsp_valid.
REQ-011 rsp_id  output  1  index of requester that issued the held result.
REQ-012 rsp_result  output  DATA_WIDTH  held ALU result.
REQ-013 rsp_eq  output  1  held equality flag, 1 iff in1 == in2.

Function
REQ-014 Block SHALL share one ALU datapath between two requesters; at most one operation accepted per cycle.
REQ-015 Output stage SHALL be a one-entry register with states EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 can_accept = EMPTY, or FULL with rsp_ready=1 (same-cycle drain and refill).
REQ-017 reqN_ready SHALL be high only when can_accept and requester N holds the grant; reqN_ready SHALL NOT depend on reqN_valid of the same requester beyond grant computation.
REQ-018 Grant: single valid requester wins; both valid -> requester other than last_id wins (round-robin).
REQ-019 last_id SHALL update to the accepted requester index only on acceptance; unchanged otherwise.
REQ-020 Latency: accepted operation SHALL appear on rsp_* exactly one cycle later; rsp_id = accepted index.
REQ-021 Transitions: EMPTY+accept -> FULL; FULL+rsp_ready+accept -> FULL (new data); FULL+rsp_ready+no accept -> EMPTY; FULL+!rsp_ready -> FULL, rsp_* stable.
REQ-022 Ops: ADD=0 in1+in2; SUB=1 in1-in2; AND=2; OR=3; XOR=4; SLT=5 signed compare -> 1/0; SLTU=6 unsigned -> 1/0; code 7 -> result 0.
REQ-023 ADD/SUB SHALL wrap modulo 2^DATA_WIDTH; no carry/overflow output.
REQ-024 rsp_eq SHALL be computed for every op code, independent of ctrl.
REQ-025 Requester holding valid without grant SHALL be served within two acceptances (starvation bound).
REQ-026 Inputs of a non-accepted requester SHALL have no effect on state.

Reset
REQ-027 With rst high at a clock edge: state EMPTY, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_eq=0, last_id=1.
REQ-028 Reset mid-operation SHALL discard any held result; no acceptance occurs in the reset cycle (req0_ready=req1_ready=0 while rst high).
REQ-029 First arbitration after reset with both valid SHALL grant requester 0.

Configuration
REQ-030 Macro ALU_ARB_FIXED_PRIO_EN: defined -> requester 0 always wins ties, last_id unused, REQ-025 void for requester 1; undefined -> round-robin per REQ-018.

Structure
REQ-031 Package alu_pkg SHALL hold alu_ctrl_t enum (3-bit codes of REQ-022) and rsp state enum {EMPTY, FULL}.
REQ-032 Combinational compute SHALL live in sub-module alu_comb (in1, in2, ctrl -> result, eq); arbiter owns all registers.

Verification
REQ-033 Reset then req0 ADD 5+7, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=12, rsp_eq=0.
REQ-034 Both valid continuously, rsp_ready=1 -> acceptances alternate 0,1,0,1 (undefined macro); all 0 (macro defined).
REQ-035 rsp_ready=0 for 3 cycles while FULL -> req*_ready=0, rsp_* stable; on rsp_ready=1 same-cycle refill, rsp_valid stays 1.
REQ-036 SUB 0-1 -> 0xFFFFFFFF; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; ctrl=7 with 9,9 -> result 0, rsp_eq=1.
REQ-037 rst asserted while FULL with rsp_ready=0 -> next cycle rsp_valid=0, last_id=1; both valid afterwards -> requester 0 granted.
